// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// forwarding-mux select codes.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXE    = 2'b01;
  localparam logic [1:0] FWD_MEM    = 2'b10;
  localparam logic [1:0] FWD_MEM_LD = 2'b11;

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Per-operand forwarding comparator: picks RF, EXE ALU, MEM ALU or MEM load
// data for one ID source register. Register $0 never matches.
module hazard_unit_fwd_select
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic              exe_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_wen,
  input  logic              mem_ren,
  output logic              exe_hit,
  output logic [1:0]        sel
);

  logic mem_hit;

  assign exe_hit = exe_wen && (exe_addr != '0) && (exe_addr == src_addr);
  assign mem_hit = mem_wen && (mem_addr != '0) && (mem_addr == src_addr);

  // The younger EXE result wins over anything still in MEM.
  always_comb begin
    sel = FWD_RF;
    if (exe_hit)
      sel = FWD_EXE;
    else if (mem_hit)
      sel = mem_ren ? FWD_MEM_LD : FWD_MEM;
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/stall/forwarding controller for the 5-stage MIPS pipeline.
// Define HAZARD_DEBUG_STEP_EN to add the debug_en/debug_step single-step freeze.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BRANCH_DELAY   = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic [ADDR_W-1:0] exe_regw_addr,
  input  logic              exe_wb_wen,
  input  logic              exe_mem_ren,
  input  logic [ADDR_W-1:0] mem_regw_addr,
  input  logic              mem_wb_wen,
  input  logic              mem_mem_ren,
  input  logic              mem_busy,
  input  logic              branch_taken,
  input  logic              exc_flush,
`ifdef HAZARD_DEBUG_STEP_EN
  input  logic              debug_en,
  input  logic              debug_step,
`endif
  output logic [1:0]        fwd_a_ctrl,
  output logic [1:0]        fwd_b_ctrl,
  output logic              fwd_m,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic       KILL_SLOT   = (BRANCH_DELAY == 0);
  localparam logic       MULTI_STALL = (LOAD_STALL_CYC > 1);
  localparam logic [2:0] LD_INIT     = 3'(LOAD_STALL_CYC - 1);

  state_t     state;
  state_t     ret;
  logic [2:0] cnt;
  logic       flush_pend;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;
  logic       rs_exe_hit;
  logic       rt_exe_hit;
  logic       hz;
  logic       flush_now;
  logic       freeze_dbg;
  logic [4:0] en_v;   // {if, id, exe, mem, wb}
  logic [4:0] rst_v;

  hazard_unit_fwd_select #(.ADDR_W(ADDR_W)) u_fwd_rs (
    .src_addr (id_rs_addr),
    .exe_addr (exe_regw_addr),
    .exe_wen  (exe_wb_wen),
    .mem_addr (mem_regw_addr),
    .mem_wen  (mem_wb_wen),
    .mem_ren  (mem_mem_ren),
    .exe_hit  (rs_exe_hit),
    .sel      (fwd_a_raw)
  );

  hazard_unit_fwd_select #(.ADDR_W(ADDR_W)) u_fwd_rt (
    .src_addr (id_rt_addr),
    .exe_addr (exe_regw_addr),
    .exe_wen  (exe_wb_wen),
    .mem_addr (mem_regw_addr),
    .mem_wen  (mem_wb_wen),
    .mem_ren  (mem_mem_ren),
    .exe_hit  (rt_exe_hit),
    .sel      (fwd_b_raw)
  );

`ifdef HAZARD_DEBUG_STEP_EN
  logic debug_step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) debug_step_q <= 1'b0;
    else     debug_step_q <= debug_step;
  end

  // A rising edge on debug_step lets exactly one cycle through.
  assign freeze_dbg = debug_en & ~(debug_step & ~debug_step_q);
`else
  assign freeze_dbg = 1'b0;
`endif

  // Store data (rt) is excluded: it can be picked up later via fwd_m.
  assign hz = exe_wb_wen & exe_mem_ren & (exe_regw_addr != '0) &
              ((id_rs_used & rs_exe_hit) | (id_rt_used & rt_exe_hit & ~id_is_store));

  assign flush_now = (state != ST_MEM_WAIT) & (exc_flush | flush_pend);

  always_comb begin
    en_v       = 5'b11111;
    rst_v      = 5'b00000;
    fwd_a_ctrl = fwd_a_raw;
    fwd_b_ctrl = fwd_b_raw;
    fwd_m      = id_is_store & id_rt_used & exe_mem_ren & rt_exe_hit;
    if (rst) begin
      rst_v      = 5'b11111;
      fwd_a_ctrl = FWD_RF;
      fwd_b_ctrl = FWD_RF;
      fwd_m      = 1'b0;
    end else if (freeze_dbg || state == ST_MEM_WAIT) begin
      en_v = 5'b00000;
    end else if (flush_now) begin
      rst_v = 5'b01110;
    end else if (mem_busy) begin
      en_v = 5'b00000;
    end else if (state == ST_LD_STALL || hz) begin
      en_v  = 5'b00111;
      rst_v = 5'b00100;
    end else if (branch_taken && KILL_SLOT) begin
      rst_v = 5'b01000;
    end
  end

  assign {if_en, id_en, exe_en, mem_en, wb_en}      = en_v;
  assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      ret        <= ST_RUN;
      cnt        <= 3'd0;
      flush_pend <= 1'b0;
    end else if (freeze_dbg || state == ST_MEM_WAIT) begin
      if (exc_flush) flush_pend <= 1'b1;
      if (!freeze_dbg && !mem_busy) state <= ret;
    end else if (flush_now) begin
      state      <= ST_RUN;
      cnt        <= 3'd0;
      flush_pend <= 1'b0;
    end else if (mem_busy) begin
      ret   <= state;
      state <= ST_MEM_WAIT;
    end else if (state == ST_LD_STALL) begin
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1) state <= ST_RUN;
    end else if (hz && MULTI_STALL) begin
      cnt   <= LD_INIT;
      state <= ST_LD_STALL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (!if_en && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (LOAD_STALL_CYC=1/BRANCH_DELAY=0/CNT_W=16 and
// LOAD_STALL_CYC=3/BRANCH_DELAY=1/CNT_W=4) share stimulus and a behavioural model.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs_addr, id_rt_addr, exe_regw_addr, mem_regw_addr;
  logic       id_rs_used, id_rt_used, id_is_store;
  logic       exe_wb_wen, exe_mem_ren, mem_wb_wen, mem_mem_ren;
  logic       mem_busy, branch_taken, exc_flush;

  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic        fm [2];
  logic [4:0]  en [2];
  logic [4:0]  rv [2];
  logic [15:0] sc_a;
  logic [3:0]  sc_b;
  logic [31:0] got_sc [2];

  assign got_sc[0] = {16'd0, sc_a};
  assign got_sc[1] = {28'd0, sc_b};

  hazard_unit #(.ADDR_W(5), .LOAD_STALL_CYC(1), .BRANCH_DELAY(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_store(id_is_store),
    .exe_regw_addr(exe_regw_addr), .exe_wb_wen(exe_wb_wen), .exe_mem_ren(exe_mem_ren),
    .mem_regw_addr(mem_regw_addr), .mem_wb_wen(mem_wb_wen), .mem_mem_ren(mem_mem_ren),
    .mem_busy(mem_busy), .branch_taken(branch_taken), .exc_flush(exc_flush),
`ifdef HAZARD_DEBUG_STEP_EN
    .debug_en(1'b0), .debug_step(1'b0),
`endif
    .fwd_a_ctrl(fa[0]), .fwd_b_ctrl(fb[0]), .fwd_m(fm[0]),
    .if_en(en[0][4]), .id_en(en[0][3]), .exe_en(en[0][2]), .mem_en(en[0][1]), .wb_en(en[0][0]),
    .if_rst(rv[0][4]), .id_rst(rv[0][3]), .exe_rst(rv[0][2]), .mem_rst(rv[0][1]), .wb_rst(rv[0][0]),
    .stall_cnt(sc_a)
  );

  hazard_unit #(.ADDR_W(5), .LOAD_STALL_CYC(3), .BRANCH_DELAY(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_store(id_is_store),
    .exe_regw_addr(exe_regw_addr), .exe_wb_wen(exe_wb_wen), .exe_mem_ren(exe_mem_ren),
    .mem_regw_addr(mem_regw_addr), .mem_wb_wen(mem_wb_wen), .mem_mem_ren(mem_mem_ren),
    .mem_busy(mem_busy), .branch_taken(branch_taken), .exc_flush(exc_flush),
`ifdef HAZARD_DEBUG_STEP_EN
    .debug_en(1'b0), .debug_step(1'b0),
`endif
    .fwd_a_ctrl(fa[1]), .fwd_b_ctrl(fb[1]), .fwd_m(fm[1]),
    .if_en(en[1][4]), .id_en(en[1][3]), .exe_en(en[1][2]), .mem_en(en[1][1]), .wb_en(en[1][0]),
    .if_rst(rv[1][4]), .id_rst(rv[1][3]), .exe_rst(rv[1][2]), .mem_rst(rv[1][1]), .wb_rst(rv[1][0]),
    .stall_cnt(sc_b)
  );

  // Model parameters and state: bubbles still owed, frozen-on-memory flag,
  // deferred flush, and the stall cycle count.
  localparam int LSC  [2] = '{1, 3};
  localparam bit KILL [2] = '{1'b1, 1'b0};
  localparam int CMAX [2] = '{65535, 15};

  int   left [2];
  bit   waiting [2];
  bit   pend [2];
  int   scnt [2];
  logic [4:0] x_en [2];
  logic [4:0] x_rst [2];
  logic [1:0] x_fa, x_fb;
  logic       x_fm;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [1:0] fwd_ref(logic [4:0] a);
    if (exe_wb_wen && exe_regw_addr != 5'd0 && exe_regw_addr == a) return 2'b01;
    if (mem_wb_wen && mem_regw_addr != 5'd0 && mem_regw_addr == a) return mem_mem_ren ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic bit hz_ref();
    if (!(exe_wb_wen && exe_mem_ren && exe_regw_addr != 5'd0)) return 1'b0;
    return (id_rs_used && id_rs_addr == exe_regw_addr) ||
           (id_rt_used && id_rt_addr == exe_regw_addr && !id_is_store);
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      left[k] = 0; waiting[k] = 0; pend[k] = 0; scnt[k] = 0;
    end
  endtask

  task automatic eval_model();
    bit h;
    h    = hz_ref();
    x_fa = rst ? 2'b00 : fwd_ref(id_rs_addr);
    x_fb = rst ? 2'b00 : fwd_ref(id_rt_addr);
    x_fm = !rst && id_is_store && id_rt_used && exe_wb_wen && exe_mem_ren &&
           exe_regw_addr != 5'd0 && exe_regw_addr == id_rt_addr;
    for (int k = 0; k < 2; k++) begin
      x_en[k]  = 5'b11111;
      x_rst[k] = 5'b00000;
      if (rst)                          x_rst[k] = 5'b11111;
      else if (waiting[k])              x_en[k]  = 5'b00000;
      else if (exc_flush || pend[k])    x_rst[k] = 5'b01110;
      else if (mem_busy)                x_en[k]  = 5'b00000;
      else if (left[k] > 0 || h) begin  x_en[k] = 5'b00111; x_rst[k] = 5'b00100; end
      else if (branch_taken && KILL[k]) x_rst[k] = 5'b01000;
    end
  endtask

  task automatic advance();
    bit h;
    h = hz_ref();
    if (rst) begin
      reset_model();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (!x_en[k][4] && scnt[k] < CMAX[k]) scnt[k]++;
      if (waiting[k]) begin
        if (exc_flush) pend[k] = 1'b1;
        if (!mem_busy) waiting[k] = 1'b0;
      end else if (exc_flush || pend[k]) begin
        left[k] = 0; pend[k] = 1'b0;
      end else if (mem_busy)   waiting[k] = 1'b1;
      else if (left[k] > 0)    left[k]--;
      else if (h)              left[k] = LSC[k] - 1;
    end
  endtask

  task automatic idle();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rs_used = 0; id_rt_used = 0; id_is_store = 0;
    exe_regw_addr = 5'd0; exe_wb_wen = 0; exe_mem_ren = 0;
    mem_regw_addr = 5'd0; mem_wb_wen = 0; mem_mem_ren = 0;
    mem_busy = 0; branch_taken = 0; exc_flush = 0;
  endtask

  task automatic rand_inputs(int busy_pct, int exc_pct, int br_pct);
    id_rs_addr    = 5'($urandom_range(0, 3));
    id_rt_addr    = 5'($urandom_range(0, 3));
    exe_regw_addr = 5'($urandom_range(0, 3));
    mem_regw_addr = 5'($urandom_range(0, 3));
    id_rs_used    = 1'($urandom_range(0, 1));
    id_rt_used    = 1'($urandom_range(0, 1));
    id_is_store   = ($urandom_range(0, 3) == 0);
    exe_wb_wen    = 1'($urandom_range(0, 1));
    exe_mem_ren   = ($urandom_range(0, 2) == 0);
    mem_wb_wen    = 1'($urandom_range(0, 1));
    mem_mem_ren   = ($urandom_range(0, 2) == 0);
    mem_busy      = ($urandom_range(0, 99) < busy_pct);
    exc_flush     = ($urandom_range(0, 99) < exc_pct);
    branch_taken  = ($urandom_range(0, 99) < br_pct);
  endtask

  task automatic to_negedge();
    eval_model();
    @(negedge clk);
  endtask

  task automatic end_cycle();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) begin
      idle();
      to_negedge();
      end_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rand_inputs(50, 50, 50);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (en[k] !== 5'b11111 || rv[k] !== 5'b11111) begin
        n_bad++; $display("FAIL reset_en_rst dut%0d got en=%b rst=%b want 11111/11111", k, en[k], rv[k]);
      end
      n_cmp++;
      if (fa[k] !== 2'b00 || fb[k] !== 2'b00 || fm[k] !== 1'b0) begin
        n_bad++; $display("FAIL reset_fwd dut%0d got %b %b %b want 00 00 0", k, fa[k], fb[k], fm[k]);
      end
      n_cmp++;
      if (got_sc[k] !== 32'd0) begin
        n_bad++; $display("FAIL reset_stall_cnt dut%0d got %0d want 0", k, got_sc[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    idle();
  endtask

  task automatic test_load_stall();
    // cycle 0: lw $5 in EXE, ID reads $5
    idle(); exe_regw_addr = 5'd5; exe_wb_wen = 1; exe_mem_ren = 1; id_rs_addr = 5'd5; id_rs_used = 1;
    to_negedge();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (en[k] !== 5'b00111 || rv[k] !== 5'b00100) begin
        n_bad++; $display("FAIL ld_bubble0 dut%0d got en=%b rst=%b want 00111/00100", k, en[k], rv[k]);
      end
    end
    end_cycle();
    // cycle 1: load now in MEM
    idle(); mem_regw_addr = 5'd5; mem_wb_wen = 1; mem_mem_ren = 1; id_rs_addr = 5'd5; id_rs_used = 1;
    to_negedge();
    n_cmp++;
    if (en[0] !== 5'b11111 || fa[0] !== 2'b11) begin
      n_bad++; $display("FAIL ld1_resume dut0 got en=%b fwd_a=%b want 11111/11", en[0], fa[0]);
    end
    n_cmp++;
    if (en[1] !== 5'b00111) begin
      n_bad++; $display("FAIL ld3_bubble1 dut1 got en=%b want 00111", en[1]);
    end
    end_cycle();
    // cycle 2: load in WB
    idle(); id_rs_addr = 5'd5; id_rs_used = 1;
    to_negedge();
    n_cmp++;
    if (en[1] !== 5'b00111 || rv[1] !== 5'b00100) begin
      n_bad++; $display("FAIL ld3_bubble2 dut1 got en=%b rst=%b want 00111/00100", en[1], rv[1]);
    end
    end_cycle();
    // cycle 3: back in RUN, value comes from the register file
    idle(); id_rs_addr = 5'd5; id_rs_used = 1;
    to_negedge();
    n_cmp++;
    if (en[1] !== 5'b11111 || fa[1] !== 2'b00) begin
      n_bad++; $display("FAIL ld3_resume dut1 got en=%b fwd_a=%b want 11111/00", en[1], fa[1]);
    end
    n_cmp++;
    if (got_sc[1] !== 32'd3 || got_sc[0] !== 32'd1) begin
      n_bad++; $display("FAIL ld_stall_cnt got %0d/%0d want 1/3", got_sc[0], got_sc[1]);
    end
    end_cycle();
  endtask

  task automatic test_forwarding();
    logic [1:0] want;
    for (int c = 0; c < 4; c++) begin
      idle(); id_rs_addr = (c == 3) ? 5'd0 : 5'd3; id_rs_used = 1;
      case (c)
        0: begin exe_regw_addr = 5'd3; exe_wb_wen = 1; want = 2'b01; end
        1: begin mem_regw_addr = 5'd3; mem_wb_wen = 1; want = 2'b10; end
        2: begin exe_regw_addr = 5'd3; exe_wb_wen = 1; mem_regw_addr = 5'd3; mem_wb_wen = 1; want = 2'b01; end
        default: begin exe_wb_wen = 1; exe_mem_ren = 1; mem_wb_wen = 1; want = 2'b00; end
      endcase
      to_negedge();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (fa[k] !== want || en[k] !== 5'b11111) begin
          n_bad++; $display("FAIL fwd_directed%0d dut%0d got fwd_a=%b en=%b want %b/11111", c, k, fa[k], en[k], want);
        end
      end
      end_cycle();
    end
    for (int i = 0; i < 60; i++) begin
      rand_inputs(0, 0, 0);
      to_negedge();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({fa[k], fb[k], fm[k], en[k], rv[k]} !== {x_fa, x_fb, x_fm, x_en[k], x_rst[k]}) begin
          n_bad++; $display("FAIL fwd_random dut%0d got %b %b %b %b %b want %b %b %b %b %b", k,
                            fa[k], fb[k], fm[k], en[k], rv[k], x_fa, x_fb, x_fm, x_en[k], x_rst[k]);
        end
      end
      end_cycle();
    end
    drain(4);
  endtask

  task automatic test_mem_busy();
    logic [4:0] want;
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) begin exe_regw_addr = 5'd6; exe_wb_wen = 1; exe_mem_ren = 1; id_rt_addr = 5'd6; id_rt_used = 1; end
      mem_busy = (c >= 1 && c <= 4);
      to_negedge();
      want = (c == 0 || c == 6 || c == 7) ? 5'b00111 : (c == 8) ? 5'b11111 : 5'b00000;
      n_cmp++;
      if (en[1] !== want) begin
        n_bad++; $display("FAIL busy_in_ldstall c%0d dut1 got en=%b want %b", c, en[1], want);
      end
      n_cmp++;
      if (en[0] !== x_en[0] || rv[0] !== x_rst[0]) begin
        n_bad++; $display("FAIL busy_model c%0d dut0 got %b/%b want %b/%b", c, en[0], rv[0], x_en[0], x_rst[0]);
      end
      end_cycle();
    end
    // flush arriving while frozen is held back until the pipe resumes
    for (int c = 0; c < 5; c++) begin
      idle();
      mem_busy  = (c < 2);
      exc_flush = (c == 1);
      to_negedge();
      want = (c == 3) ? 5'b01110 : 5'b00000;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rv[k] !== want || en[k] !== ((c < 3) ? 5'b00000 : 5'b11111)) begin
          n_bad++; $display("FAIL busy_flush c%0d dut%0d got en=%b rst=%b want rst %b", c, k, en[k], rv[k], want);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_branch_flush();
    for (int c = 0; c < 4; c++) begin
      idle();
      branch_taken = (c < 3);
      exc_flush    = (c == 2);
      if (c == 1) begin exe_regw_addr = 5'd7; exe_wb_wen = 1; exe_mem_ren = 1; id_rs_addr = 5'd7; id_rs_used = 1; end
      to_negedge();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (en[k] !== x_en[k] || rv[k] !== x_rst[k]) begin
          n_bad++; $display("FAIL branch_flush c%0d dut%0d got %b/%b want %b/%b", c, k, en[k], rv[k], x_en[k], x_rst[k]);
        end
      end
      if (c == 0) begin
        n_cmp++;
        if (rv[0] !== 5'b01000 || rv[1] !== 5'b00000) begin
          n_bad++; $display("FAIL branch_kill got %b/%b want 01000/00000", rv[0], rv[1]);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (rv[0] !== 5'b01110 || rv[1] !== 5'b01110) begin
          n_bad++; $display("FAIL exc_flush got %b/%b want 01110/01110", rv[0], rv[1]);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 20; c++) begin
      idle(); mem_busy = 1;
      to_negedge();
      end_cycle();
    end
    drain(2);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got_sc[k] !== 32'(scnt[k])) begin
        n_bad++; $display("FAIL stall_cnt_sat dut%0d got %0d want %0d", k, got_sc[k], scnt[k]);
      end
    end
    n_cmp++;
    if (got_sc[1] !== 32'd15) begin
      n_bad++; $display("FAIL stall_cnt_hold dut1 got %0d want 15", got_sc[1]);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle(); exe_regw_addr = 5'd9; exe_wb_wen = 1; exe_mem_ren = 1; id_rs_addr = 5'd9; id_rs_used = 1;
    to_negedge();
    end_cycle();
    idle();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (en[k] !== 5'b11111 || rv[k] !== 5'b11111 || got_sc[k] !== 32'd0) begin
        n_bad++; $display("FAIL rst_mid_stall dut%0d got en=%b rst=%b cnt=%0d want 11111/11111/0", k, en[k], rv[k], got_sc[k]);
      end
    end
    #1 rst = 1'b0;
    reset_model();
    to_negedge();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (en[k] !== 5'b11111 || rv[k] !== 5'b00000) begin
        n_bad++; $display("FAIL rst_no_residual dut%0d got en=%b rst=%b want 11111/00000", k, en[k], rv[k]);
      end
    end
    end_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs(12, 6, 25);
      to_negedge();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({fa[k], fb[k], fm[k], en[k], rv[k]} !== {x_fa, x_fb, x_fm, x_en[k], x_rst[k]} ||
            got_sc[k] !== 32'(scnt[k])) begin
          n_bad++; $display("FAIL random%0d dut%0d got %b %b %b %b %b cnt=%0d want %b %b %b %b %b cnt=%0d", i, k,
                            fa[k], fb[k], fm[k], en[k], rv[k], got_sc[k],
                            x_fa, x_fb, x_fm, x_en[k], x_rst[k], scnt[k]);
        end
      end
      end_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    reset_model();
    @(posedge clk); #1;
    test_reset();
    test_load_stall();
    test_forwarding();
    test_mem_busy();
    test_branch_flush();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
